exec_stage: RTL and testbench

EXEC_STAGE -- requirements
Module: exec_stage

---
 rtl/exec_stage_pkg.sv | 44 ++++
 rtl/exec_stage_alu.sv | 43 ++++
 rtl/exec_stage.sv | 106 ++++++++++
 tb/tb_exec_stage.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_stage_pkg.sv
// Shared definitions for the execute stage: ALU control codes, the decoded
// control struct and the decode helpers used by the pipeline front end.
package exec_stage_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    typedef struct packed {
        logic       invert_a;
        logic       invert_b;
        logic [1:0] operation;
    } alu_ctrl_t;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

    function automatic alu_ctrl_t decode_op(input logic [3:0] op);
        alu_ctrl_t c;
        case (op)
            OP_AND:  c = '{1'b0, 1'b0, 2'b00};
            OP_OR:   c = '{1'b0, 1'b0, 2'b01};
            OP_ADD:  c = '{1'b0, 1'b0, 2'b10};
            OP_SUB:  c = '{1'b0, 1'b1, 2'b10};
            OP_SLT:  c = '{1'b0, 1'b1, 2'b11};
            OP_NOR:  c = '{1'b1, 1'b1, 2'b00};
            default: c = '{1'b0, 1'b0, 2'b00};
        endcase
        return c;
    endfunction

    // Only ADD and SUB report overflow; SLT shares the adder but not the flag.
    function automatic logic is_addsub(input alu_ctrl_t c);
        return (c.operation == 2'b10) && !c.invert_a;
    endfunction

endpackage

// File: rtl/exec_stage_alu.sv
// 32-bit ripple-carry ALU: optional operand inversion feeding AND/OR/ADD/SLT.
module ALU
    import exec_stage_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  alu_ctrl_t   ctrl_i,
    output logic [31:0] result_o,
    output logic        ovf_o
);
    logic [31:0] a_x, b_x, sum;
    logic        c31, c32, less;

    assign a_x = ctrl_i.invert_a ? ~a_i : a_i;
    assign b_x = ctrl_i.invert_b ? ~b_i : b_i;

    // Carry-in equals invert_b so SUB/SLT form the two's complement of B.
    always_comb begin
        logic c;
        c   = ctrl_i.invert_b;
        c31 = 1'b0;
        sum = '0;
        for (int i = 0; i < 32; i++) begin
            if (i == 31) c31 = c;
            sum[i] = a_x[i] ^ b_x[i] ^ c;
            c      = (a_x[i] & b_x[i]) | (c & (a_x[i] ^ b_x[i]));
        end
        c32 = c;
    end

    assign ovf_o = c31 ^ c32;
    assign less  = sum[31] ^ ovf_o;

    always_comb begin
        case (ctrl_i.operation)
            2'b00:   result_o = a_x & b_x;
            2'b01:   result_o = a_x | b_x;
            2'b10:   result_o = sum;
            default: result_o = {31'b0, less};
        endcase
    end

endmodule

// File: rtl/exec_stage.sv
// Two-stage execute pipeline: S1 holds operands and decoded controls, S2 holds
// the ALU result and flags, with valid/ready flow control and an overflow counter.
module exec_stage
    import exec_stage_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_src1,
    input  logic [31:0]      in_src2,
    input  logic [3:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_zero,
    output logic             out_ovf,
    output logic             out_illegal,
    output logic [CNT_W-1:0] ovf_count,
    input  logic             ovf_clear
);
    logic             s1_valid_q, s1_ill_q;
    logic [31:0]      s1_a_q, s1_b_q;
    alu_ctrl_t        s1_ctrl_q;
    logic             s2_valid_q, s2_zero_q, s2_ovf_q, s2_ill_q;
    logic [31:0]      s2_res_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s2_adv;
    logic [31:0]      alu_res, res_d;
    logic             alu_ovf, ovf_d;

    // S2 frees up when empty or draining; in_ready never looks at in_valid.
    assign s2_adv   = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_adv;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_ill_q   <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_ctrl_q  <= '0;
        end else if (in_ready) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_a_q    <= in_src1;
                s1_b_q    <= in_src2;
                s1_ctrl_q <= decode_op(in_op);
                s1_ill_q  <= !op_legal(in_op);
            end
        end
    end

    ALU u_alu (
        .a_i      (s1_a_q),
        .b_i      (s1_b_q),
        .ctrl_i   (s1_ctrl_q),
        .result_o (alu_res),
        .ovf_o    (alu_ovf)
    );

    assign res_d = s1_ill_q ? '0 : alu_res;
    assign ovf_d = !s1_ill_q && is_addsub(s1_ctrl_q) && alu_ovf;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_res_q   <= '0;
            s2_zero_q  <= 1'b0;
            s2_ovf_q   <= 1'b0;
            s2_ill_q   <= 1'b0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_res_q  <= res_d;
                s2_zero_q <= (res_d == 32'h0);
                s2_ovf_q  <= ovf_d;
                s2_ill_q  <= s1_ill_q;
            end
        end
    end

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (ovf_clear)
            cnt_d = '0;
        else if (s2_valid_q && out_ready && s2_ovf_q && (cnt_q != '1))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign out_valid   = s2_valid_q;
    assign out_result  = s2_res_q;
    assign out_zero    = s2_zero_q;
    assign out_ovf     = s2_ovf_q;
    assign out_illegal = s2_ill_q;
    assign ovf_count   = cnt_q;

endmodule

// File: tb/tb_exec_stage.sv
// Randomized bench for exec_stage: a queue-based reference model checked every
// cycle, plus directed cases with literal expected values.
module tb_exec_stage;
    localparam int TB_CNT_W = 2;
    localparam int SAT      = 3;

    logic              clk_i = 1'b0;
    logic              rst_n;
    logic              in_valid, in_ready;
    logic [31:0]       in_src1, in_src2;
    logic [3:0]        in_op;
    logic              out_valid, out_ready;
    logic [31:0]       out_result;
    logic              out_zero, out_ovf, out_illegal;
    logic [TB_CNT_W-1:0] ovf_count;
    logic              ovf_clear;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    exec_stage #(.CNT_W(TB_CNT_W)) dut (
        .clk_i      (clk_i),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_src1    (in_src1),
        .in_src2    (in_src2),
        .in_op      (in_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_ovf    (out_ovf),
        .out_illegal(out_illegal),
        .ovf_count  (ovf_count),
        .ovf_clear  (ovf_clear)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        ovf;
        logic        ill;
        int          ready_at;
    } exp_t;

    exp_t q[$];
    int   cnt_m = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.res = 32'h0; e.ovf = 1'b0; e.ill = 1'b0; e.ready_at = 0;
        case (op)
            4'b0000: e.res = a & b;
            4'b0001: e.res = a | b;
            4'b0010: begin
                e.res = a + b;
                e.ovf = (a[31] == b[31]) && (e.res[31] != a[31]);
            end
            4'b0110: begin
                e.res = a - b;
                e.ovf = (a[31] != b[31]) && (e.res[31] != a[31]);
            end
            4'b0111: e.res = ($signed(a) < $signed(b)) ? 32'h1 : 32'h0;
            4'b1100: e.res = ~(a | b);
            default: e.ill = 1'b1;
        endcase
        e.zero = (e.res == 32'h0);
        return e;
    endfunction

    // Per-cycle compare against the model; sampled mid-cycle, inputs are stable.
    always @(negedge clk_i) begin
        if (!rst_n) begin
            chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
            chk("rst_out_result", out_result, 32'h0);
            chk("rst_flags", {29'b0, out_zero, out_ovf, out_illegal}, 32'h0);
            chk("rst_ovf_count", {30'b0, ovf_count}, 32'h0);
            q.delete();
            cnt_m = 0;
        end else begin
            logic exp_rdy, exp_v, xovf;
            exp_t e;
            exp_rdy = (q.size() < 2) || out_ready;
            exp_v   = (q.size() > 0) && (cyc >= q[0].ready_at);
            chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
            chk("out_valid", {31'b0, out_valid}, {31'b0, exp_v});
            if (exp_v && out_valid) begin
                chk("out_result", out_result, q[0].res);
                chk("out_flags", {29'b0, out_zero, out_ovf, out_illegal},
                    {29'b0, q[0].zero, q[0].ovf, q[0].ill});
            end
            chk("ovf_count", {30'b0, ovf_count}, cnt_m[31:0]);
            xovf = 1'b0;
            if (exp_v && out_ready) begin
                xovf = q[0].ovf;
                void'(q.pop_front());
            end
            if (ovf_clear)             cnt_m = 0;
            else if (xovf && cnt_m < SAT) cnt_m++;
            if (in_valid && exp_rdy) begin
                e = model(in_op, in_src1, in_src2);
                e.ready_at = cyc + 2;
                q.push_back(e);
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Issue one op into an idle pipe with out_ready=1; leaves the result visible.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b;
        step();
        in_valid = 1'b0;
        step();
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0: v = 32'h7FFF_FFFF;
            1: v = 32'h8000_0000;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'h0;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    logic [31:0] got_r [3];
    logic [3:0]  legal_ops [6];

    initial begin
        int got;
        legal_ops[0] = 4'b0000; legal_ops[1] = 4'b0001; legal_ops[2] = 4'b0010;
        legal_ops[3] = 4'b0110; legal_ops[4] = 4'b0111; legal_ops[5] = 4'b1100;
        rst_n = 1'b0; in_valid = 1'b0; in_src1 = '0; in_src2 = '0; in_op = '0;
        out_ready = 1'b0; ovf_clear = 1'b0;
        step();
        chk("reset_out_valid", {31'b0, out_valid}, 32'h0);
        chk("reset_in_ready", {31'b0, in_ready}, 32'h1);
        #2 rst_n = 1'b1;
        step();
        chk("post_reset_in_ready", {31'b0, in_ready}, 32'h1);

        // Signed overflow on ADD, visible two cycles after acceptance.
        out_ready = 1'b1;
        issue(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
        chk("add_ovf_result", out_result, 32'h8000_0000);
        chk("add_ovf_flags", {30'b0, out_ovf, out_zero}, 32'h2);
        step();
        chk("add_ovf_count", {30'b0, ovf_count}, 32'h1);
        step();

        issue(4'b0110, 32'd5, 32'd5);
        chk("sub_zero_result", out_result, 32'h0);
        chk("sub_zero_flags", {30'b0, out_zero, out_ovf}, 32'h2);
        step(); step();

        issue(4'b0111, 32'hFFFF_FFFF, 32'h1);
        chk("slt_neg_result", out_result, 32'h1);
        step(); step();

        issue(4'b0101, 32'h1234_5678, 32'h9ABC_DEF0);
        chk("illegal_flags", {30'b0, out_illegal, out_zero}, 32'h3);
        chk("illegal_result", out_result, 32'h0);
        step(); step();

        // Back-to-back AND, OR, NOR under a 3-cycle downstream stall.
        out_ready = 1'b0;
        in_src1 = 32'hF0F0_00FF; in_src2 = 32'h0FF0_0F0F;
        in_valid = 1'b1; in_op = 4'b0000;
        step();
        in_op = 4'b0001;
        step();
        in_op = 4'b1100;
        step();
        chk("stall_in_ready", {31'b0, in_ready}, 32'h0);
        chk("stall_out_valid", {31'b0, out_valid}, 32'h1);
        out_ready = 1'b1;
        got = 0;
        for (int k = 0; k < 8 && got < 3; k++) begin
            if (out_valid) begin
                got_r[got] = out_result;
                got++;
            end
            step();
            if (k == 0) in_valid = 1'b0;
        end
        chk("stall_delivered", got, 3);
        if (got == 3) begin
            chk("stall_and", got_r[0], 32'h00F0_000F);
            chk("stall_or",  got_r[1], 32'hFFF0_0FFF);
            chk("stall_nor", got_r[2], 32'h000F_F000);
        end
        step(); step();

        // Counter saturation and clear-over-increment priority.
        ovf_clear = 1'b1;
        step();
        ovf_clear = 1'b0;
        chk("clear_count", {30'b0, ovf_count}, 32'h0);
        in_valid = 1'b1; in_op = 4'b0010; in_src1 = 32'h7FFF_FFFF; in_src2 = 32'h1;
        repeat (5) step();
        in_valid = 1'b0;
        repeat (4) step();
        chk("sat_count", {30'b0, ovf_count}, 32'h3);
        issue(4'b0010, 32'h8000_0000, 32'h8000_0000);
        chk("clr_pri_ovf", {31'b0, out_ovf}, 32'h1);
        ovf_clear = 1'b1;
        step();
        ovf_clear = 1'b0;
        chk("clr_pri_count", {30'b0, ovf_count}, 32'h0);

        // Reset with both stages full.
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 4'b0010; in_src1 = 32'h7FFF_FFFF; in_src2 = 32'h1;
        step(); step();
        in_valid = 1'b0;
        chk("full_out_valid", {31'b0, out_valid}, 32'h1);
        chk("full_in_ready", {31'b0, in_ready}, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'b0, out_valid}, 32'h0);
        chk("async_rst_result", out_result, 32'h0);
        step(); step();
        #2 rst_n = 1'b1;
        step();
        chk("rel_in_ready", {31'b0, in_ready}, 32'h1);
        out_ready = 1'b1;
        repeat (3) begin
            chk("no_stale_valid", {31'b0, out_valid}, 32'h0);
            step();
        end

        // Random traffic against the model.
        for (int n = 0; n < 800; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_op     = ($urandom_range(0, 9) == 0) ? 4'($urandom) : legal_ops[$urandom_range(0, 5)];
            in_src1   = pick_operand();
            in_src2   = pick_operand();
            out_ready = ($urandom_range(0, 2) != 0);
            ovf_clear = ($urandom_range(0, 39) == 0);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1; ovf_clear = 1'b0;
        repeat (6) step();
        chk("drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
